// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the keypad scanner. Holds the scan and
//               debounce FSM state encoding only. Widths that depend on
//               parameters live in the modules that own those parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // FSM state encoding. Every state value has an explicit 2-bit width.
    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,  // rotating the one-hot row drive
        ST_PRESS_DB   = 2'd1,  // row frozen, waiting for a stable column pattern
        ST_HELD       = 2'd2,  // key reported (or dropped), waiting for release
        ST_RELEASE_DB = 2'd3   // waiting for stable all-zero columns
    } kp_state_e;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Stability counter shared by the press and release debounce
//               phases. It counts consecutive cycles in which 'sample' equals
//               'ref_pattern' while 'enable' is high. Any mismatch, or a low
//               'enable', clears the count. The counter saturates and never
//               wraps.
// Revision    : 1.0 - initial release
//
// Ports
//   clk         : in  - rising-edge clock
//   reset       : in  - asynchronous active-low reset
//   enable      : in  - counting allowed (a debounce state is active)
//   sample      : in  - current column sample
//   ref_pattern : in  - pattern the sample must equal to count as stable
//   match       : out - sample == ref_pattern (combinational)
//   done        : out - this sample completes DEBOUNCE_CYCLES stable cycles
// ============================================================================
module keypad_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] ref_pattern,
    output logic             match,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_count;

    assign match   = (sample == ref_pattern);
    assign w_count = enable && match;

    // 'done' fires on the sample that would bring the count to
    // DEBOUNCE_CYCLES. The owner FSM can then change state on that same edge.
    assign done = w_count && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!w_count) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : keypad_debounce
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Row-scanning matrix keypad controller. It drives one row at a
//               time and senses the columns. When a key is detected, it freezes
//               the row, debounces the press and the release, and reports one
//               (row, col) event per press on a valid/ready handshake.
// Revision    : 1.0 - initial release
//
// Build option
//   KEYPAD_SYNC_EN : when defined, 'cols' passes through a two-flop
//                    synchronizer before any decision is made (2-cycle
//                    latency). When undefined, 'cols' is used directly.
//
// Ports
//   clk         : in  - sole clock, rising edge
//   reset       : in  - asynchronous active-low reset
//   cols        : in  - column sense lines, active-high, asynchronous
//   rows        : out - one-hot row drive, active-high
//   key_valid   : out - debounced key event available
//   key_ready   : in  - consumer accepts the event when high with key_valid
//   key_row     : out - row index of the event
//   key_col     : out - column index (lowest set bit of the pattern)
//   key_overrun : out - one-cycle pulse when a press is dropped because the
//                       previous event was still pending
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_COLS-1:0]         cols,
    output logic [NUM_ROWS-1:0]         rows,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [$clog2(NUM_ROWS)-1:0] key_row,
    output logic [$clog2(NUM_COLS)-1:0] key_col,
    output logic                        key_overrun
);

    localparam int c_row_w   = $clog2(NUM_ROWS);
    localparam int c_col_w   = $clog2(NUM_COLS);
    localparam int c_cnt_max = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    kp_state_e              r_state;
    logic [c_row_w-1:0]     r_row_idx;
    logic [c_cnt_w-1:0]     r_scan_cnt;
    logic [NUM_COLS-1:0]    r_pattern;
    logic                   r_key_valid;
    logic [c_row_w-1:0]     r_key_row;
    logic [c_col_w-1:0]     r_key_col;
    logic                   r_key_overrun;

    logic [NUM_COLS-1:0]    w_cols;
    logic                   w_cols_nz;
    logic [c_row_w-1:0]     w_row_next;
    logic [c_col_w-1:0]     w_lsb_col;
    logic                   w_db_enable;
    logic [NUM_COLS-1:0]    w_db_ref;
    logic                   w_db_match;
    logic                   w_db_done;
    logic                   w_event;

    // ------------------------------------------------------------------
    // Column input conditioning
    // ------------------------------------------------------------------
`ifdef KEYPAD_SYNC_EN
    logic [NUM_COLS-1:0] r_cols_meta;
    logic [NUM_COLS-1:0] r_cols_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cols_meta <= '0;
            r_cols_sync <= '0;
        end else begin
            r_cols_meta <= cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    assign w_cols = r_cols_sync;
`else
    assign w_cols = cols;
`endif

    assign w_cols_nz  = |w_cols;
    assign w_row_next = (r_row_idx == c_row_w'(NUM_ROWS - 1)) ? '0
                                                               : r_row_idx + c_row_w'(1);

    // Priority encoder for the lowest set column. Scanning from the top down
    // lets the lowest set bit be the final value written.
    always_comb begin
        w_lsb_col = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (r_pattern[i]) begin
                w_lsb_col = c_col_w'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared debounce counter. During a press it compares against the
    // captured pattern. During a release it compares against all-zero.
    // ------------------------------------------------------------------
    assign w_db_enable = (r_state == ST_PRESS_DB) || (r_state == ST_RELEASE_DB);
    assign w_db_ref    = (r_state == ST_RELEASE_DB) ? '0 : r_pattern;

    keypad_debounce #(
        .WIDTH           (NUM_COLS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (c_cnt_w)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .enable      (w_db_enable),
        .sample      (w_cols),
        .ref_pattern (w_db_ref),
        .match       (w_db_match),
        .done        (w_db_done)
    );

    // A debounced press completes on this edge.
    assign w_event = (r_state == ST_PRESS_DB) && w_db_done;

    // ------------------------------------------------------------------
    // Scan / debounce FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= '0;
            r_scan_cnt <= '0;
            r_pattern  <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_cols_nz) begin
                        r_pattern  <= w_cols;
                        r_scan_cnt <= '0;
                        r_state    <= ST_PRESS_DB;
                    end else if (r_scan_cnt == c_cnt_w'(SCAN_DIV - 1)) begin
                        r_scan_cnt <= '0;
                        r_row_idx  <= w_row_next;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + c_cnt_w'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_cols_nz) begin
                        r_state   <= ST_SCAN;
                        r_row_idx <= w_row_next;
                    end else if (!w_db_match) begin
                        // A different key combination settled in. Restart the
                        // debounce on the new pattern. The counter clears
                        // itself on the mismatch.
                        r_pattern <= w_cols;
                    end else if (w_db_done) begin
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!w_cols_nz) begin
                        r_state <= ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_cols_nz) begin
                        r_state <= ST_HELD;
                    end else if (w_db_done) begin
                        r_state   <= ST_SCAN;
                        r_row_idx <= w_row_next;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event output. The handshake runs independently of the FSM, so a
    // consumer may accept at any time. A press that completes while an
    // event is still pending is dropped, and the pending data stays intact.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_valid   <= 1'b0;
            r_key_row     <= '0;
            r_key_col     <= '0;
            r_key_overrun <= 1'b0;
        end else begin
            r_key_overrun <= w_event && r_key_valid;
            if (r_key_valid) begin
                if (key_ready) begin
                    r_key_valid <= 1'b0;
                end
            end else if (w_event) begin
                r_key_valid <= 1'b1;
                r_key_row   <= r_row_idx;
                r_key_col   <= w_lsb_col;
            end
        end
    end

    assign rows        = NUM_ROWS'(1) << r_row_idx;
    assign key_valid   = r_key_valid;
    assign key_row     = r_key_row;
    assign key_col     = r_key_col;
    assign key_overrun = r_key_overrun;

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner with
//               NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8 and
//               KEYPAD_SYNC_EN undefined. Inputs change and outputs are
//               sampled 1 time unit after each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       key_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(
        .NUM_ROWS        (4),
        .NUM_COLS        (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cols        (cols),
        .rows        (rows),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rows"},    32'(rows),        32'h1);
        check({tag, "_valid"},   32'(key_valid),   32'h0);
        check({tag, "_row"},     32'(key_row),     32'h0);
        check({tag, "_col"},     32'(key_col),     32'h0);
        check({tag, "_overrun"}, 32'(key_overrun), 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        cols      = 4'b0000;
        key_ready = 1'b0;

        // Reset state
        step(3);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle scanning: 4 cycles per row, wrapping
        check("idle_rows_k0", 32'(rows), 32'h1);
        for (int k = 1; k <= 32; k++) begin
            step(1);
            check($sformatf("idle_rows_k%0d", k), 32'(rows), 32'(4'b0001 << ((k / 4) % 4)));
            check($sformatf("idle_valid_k%0d", k), 32'(key_valid), 32'h0);
        end

        // Short bounce on row 0: capture + 4 matches, then release
        cols = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check($sformatf("bounce_rows_%0d", i), 32'(rows), 32'h1);
        end
        cols = 4'b0000;
        step(1);
        check("bounce_rows_after", 32'(rows), 32'h2);
        check("bounce_valid", 32'(key_valid), 32'h0);

        // Clean press on row 1 col 2 with key_ready high
        key_ready = 1'b1;
        cols = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check($sformatf("press_valid_%0d", i), 32'(key_valid), 32'(i == 9));
            check($sformatf("press_rows_%0d", i), 32'(rows), 32'h2);
            if (i == 9) begin
                check("press_row", 32'(key_row), 32'h1);
                check("press_col", 32'(key_col), 32'h2);
            end
        end
        cols = 4'b0000;
        step(8);
        check("release_rows_frozen", 32'(rows), 32'h2);
        step(1);
        check("release_rows_next", 32'(rows), 32'h4);
        check("release_valid", 32'(key_valid), 32'h0);

        // Overrun: first press row 2 col 3 stays pending
        key_ready = 1'b0;
        cols = 4'b1000;
        step(10);
        check("ovr_first_valid", 32'(key_valid), 32'h1);
        check("ovr_first_row", 32'(key_row), 32'h2);
        check("ovr_first_col", 32'(key_col), 32'h3);
        cols = 4'b0000;
        step(9);
        check("ovr_rows_row3", 32'(rows), 32'h8);
        cols = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("ovr_pulse_%0d", i), 32'(key_overrun), 32'(i == 9));
            check($sformatf("ovr_valid_%0d", i), 32'(key_valid), 32'h1);
        end
        check("ovr_kept_row", 32'(key_row), 32'h2);
        check("ovr_kept_col", 32'(key_col), 32'h3);
        key_ready = 1'b1;
        step(1);
        check("ovr_accept_valid", 32'(key_valid), 32'h0);
        cols = 4'b0000;
        step(9);
        check("ovr_wrap_rows", 32'(rows), 32'h1);

        // Multi-bit pattern on row 0 plus a 3-cycle release glitch
        cols = 4'b1010;
        step(9);
        check("multi_valid", 32'(key_valid), 32'h1);
        check("multi_row", 32'(key_row), 32'h0);
        check("multi_col", 32'(key_col), 32'h1);
        step(3);
        check("multi_valid_acc", 32'(key_valid), 32'h0);
        cols = 4'b0000;
        step(3);
        cols = 4'b1010;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check($sformatf("glitch_valid_%0d", i), 32'(key_valid), 32'h0);
            check($sformatf("glitch_rows_%0d", i), 32'(rows), 32'h1);
        end
        cols = 4'b0000;
        step(9);
        check("glitch_end_rows", 32'(rows), 32'h2);
        check("glitch_end_valid", 32'(key_valid), 32'h0);

        // Reset during PRESS_DB on row 1
        cols = 4'b0100;
        step(3);
        check("rst1_rows_before", 32'(rows), 32'h2);
        #2;
        reset = 1'b0;
        cols  = 4'b0000;
        #1;
        check_reset_outputs("rst1");
        step(1);
        reset = 1'b1;
        check("rst1_rows_rel", 32'(rows), 32'h1);
        step(1);
        check("rst1_rows_rel1", 32'(rows), 32'h1);

        // Reset with key_valid pending
        key_ready = 1'b0;
        cols = 4'b0010;
        step(9);
        check("rst2_valid_before", 32'(key_valid), 32'h1);
        check("rst2_col_before", 32'(key_col), 32'h1);
        #2;
        reset = 1'b0;
        cols  = 4'b0000;
        #1;
        check_reset_outputs("rst2");
        step(1);
        reset = 1'b1;
        step(1);
        check("rst2_rows_rel", 32'(rows), 32'h1);
        check("rst2_valid_rel", 32'(key_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_keypad_scanner
`default_nettype wire
